// File: rtl/byte_stuffer.sv
// JPEG entropy-stream byte stuffer: inserts 0x00 after every 0xFF and queues the
// stuffed stream in a circular buffer that drains at one byte per clock.
module byte_stuffer #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in_valid,
  input  logic [7:0] data_in,
  output logic       data_out_valid,
  output logic [7:0] data_out,
  output logic       overflow
);

  localparam logic [ADDR_W:0]   DepthC = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CntTwo = (ADDR_W + 1)'(2);
  localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              data_out_valid_q;
  logic [7:0]        data_out_q;
  logic              overflow_q;

  logic              isFf;
  logic [ADDR_W:0]   need;
  logic [ADDR_W:0]   free;
  logic              doWrite;
  logic              doDrop;
  logic              doPop;

  // Credit is judged on the occupancy before this cycle's pop, so a byte
  // leaving the buffer never makes room for a byte arriving in the same cycle.
  always_comb begin
    isFf     = (data_in == 8'hFF);
    need     = isFf ? CntTwo : CntOne;
    free     = DepthC - count_q;
    doWrite  = data_in_valid && (free >= need);
    doDrop   = data_in_valid && !doWrite;
    doPop    = (count_q != '0);
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (doWrite) begin
      count_d  = count_d + need;
      wr_ptr_d = wr_ptr_q + need[ADDR_W-1:0];
    end
    if (doPop) begin
      count_d  = count_d - CntOne;
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // The stuffed 00 goes through a second write port so an FF costs one cycle.
  always_ff @(posedge clock) begin
    if (doWrite) begin
      mem[wr_ptr_q] <= data_in;
      if (isFf) begin
        mem[wr_ptr_q + PtrOne] <= 8'h00;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      data_out_valid_q <= 1'b0;
      data_out_q       <= 8'h00;
      overflow_q       <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      data_out_valid_q <= doPop;
      if (doPop) begin
        data_out_q <= mem[rd_ptr_q];
      end
      if (doDrop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign data_out_valid = data_out_valid_q;
  assign data_out       = data_out_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_byte_stuffer.sv
// Self-checking bench for byte_stuffer: a queue-based model of the stuffed stream
// predicts every output cycle, plus directed checks for latency, fill and reset.
module tb_byte_stuffer;

  localparam int DEPTH = 1024;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_out_valid;
  logic [7:0] data_out;
  logic       overflow;

  byte_stuffer #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: bytes waiting in the buffer, plus the expected output registers.
  logic [7:0] modelQ[$];
  logic       expValid = 1'b0;
  logic [7:0] expData = 8'h00;
  logic       expOv = 1'b0;
  int         compared = 0;
  int         mismatched = 0;

  // Drives one clock of stimulus and advances the model; outputs are sampled 1 unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    int pre;
    int need;
    reset = r;
    data_in_valid = v;
    data_in = d;
    @(posedge clock);
    if (r) begin
      modelQ.delete();
      expValid = 1'b0;
      expData = 8'h00;
      expOv = 1'b0;
    end else begin
      pre = modelQ.size();
      expValid = (pre > 0);
      if (pre > 0) expData = modelQ.pop_front();
      if (v) begin
        need = (d == 8'hFF) ? 2 : 1;
        if (DEPTH - pre >= need) begin
          modelQ.push_back(d);
          if (d == 8'hFF) modelQ.push_back(8'h00);
        end else begin
          expOv = 1'b1;
        end
      end
    end
    #1;
    reset = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    compared++;
    if (data_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_valid: got %b want 0", data_out_valid);
    end
    compared++;
    if (data_out !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got %h want 00", data_out);
    end
    compared++;
    if (overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_single_byte();
    step(1'b1, 8'h12, 1'b0);
    compared++;
    if (data_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_edge1_valid: got %b want 0", data_out_valid);
    end
    step(1'b0, 8'h00, 1'b0);
    compared++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h12) begin
      mismatched++;
      $display("[TB] FAIL single_edge2: got valid=%b data=%h want valid=1 data=12", data_out_valid, data_out);
    end
    step(1'b0, 8'h00, 1'b0);
    compared++;
    if (data_out_valid !== 1'b0 || data_out !== 8'h12) begin
      mismatched++;
      $display("[TB] FAIL single_edge3: got valid=%b data=%h want valid=0 data=12", data_out_valid, data_out);
    end
  endtask

  task automatic test_single_ff();
    step(1'b1, 8'hFF, 1'b0);
    compared++;
    if (data_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ff_edge1_valid: got %b want 0", data_out_valid);
    end
    step(1'b0, 8'h00, 1'b0);
    compared++;
    if (data_out_valid !== 1'b1 || data_out !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL ff_first: got valid=%b data=%h want valid=1 data=ff", data_out_valid, data_out);
    end
    step(1'b0, 8'h00, 1'b0);
    compared++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL ff_stuffed: got valid=%b data=%h want valid=1 data=00", data_out_valid, data_out);
    end
    step(1'b0, 8'h00, 1'b0);
    compared++;
    if (data_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ff_after: got valid=%b want 0", data_out_valid);
    end
  endtask

  task automatic test_random_stream();
    int pcts[4] = '{0, 15, 30, 50};
    int sent = 0;
    int ffSent = 0;
    int seen = 0;
    int drain = 0;
    int gapLeft = 0;
    logic [7:0] d;
    while (sent < 10000 || drain < 1100) begin
      if (sent < 10000 && gapLeft == 0) begin
        if ($urandom_range(0, 99) < pcts[sent / 2500]) d = 8'hFF;
        else d = 8'($urandom_range(0, 254));
        step(1'b1, d, 1'b0);
        sent++;
        if (d == 8'hFF) ffSent++;
        gapLeft = 0;
        while ($urandom_range(0, 99) < 45 && gapLeft < 16) gapLeft++;
      end else begin
        step(1'b0, 8'h00, 1'b0);
        if (sent >= 10000) drain++;
        else gapLeft--;
      end
      if (data_out_valid === 1'b1) seen++;
      compared++;
      if (data_out_valid !== expValid || data_out !== expData || overflow !== expOv) begin
        mismatched++;
        $display("[TB] FAIL random_cycle: got valid=%b data=%h ovf=%b want valid=%b data=%h ovf=%b",
                 data_out_valid, data_out, overflow, expValid, expData, expOv);
      end
    end
    compared++;
    if (overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL random_overflow: got %b want 0", overflow);
    end
    compared++;
    if (seen !== sent + ffSent) begin
      mismatched++;
      $display("[TB] FAIL random_out_count: got %0d want %0d", seen, sent + ffSent);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    for (int i = 0; i < 1016 + 1200; i++) begin
      if (i < 1016) step(1'b1, 8'hFF, 1'b0);
      else step(1'b0, 8'h00, 1'b0);
      if (data_out_valid === 1'b1) begin
        compared++;
        if (data_out !== ((seen % 2 == 0) ? 8'hFF : 8'h00)) begin
          mismatched++;
          $display("[TB] FAIL burst_byte%0d: got %h want %h", seen, data_out, (seen % 2 == 0) ? 8'hFF : 8'h00);
        end
        seen++;
      end
      compared++;
      if (data_out_valid !== expValid || overflow !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL burst_cycle%0d: got valid=%b ovf=%b want valid=%b ovf=0", i, data_out_valid, overflow, expValid);
      end
    end
    compared++;
    if (seen !== 2032) begin
      mismatched++;
      $display("[TB] FAIL burst_out_count: got %0d want 2032", seen);
    end
    compared++;
    if (data_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL burst_drained: got valid=%b want 0", data_out_valid);
    end
  endtask

  task automatic test_fill_overflow();
    logic wantOv;
    for (int i = 1; i <= 3000; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      wantOv = (i >= 1023);
      compared++;
      if (overflow !== wantOv) begin
        mismatched++;
        $display("[TB] FAIL fill_overflow_byte%0d: got %b want %b", i, overflow, wantOv);
      end
      compared++;
      if (data_out_valid !== expValid || data_out !== expData) begin
        mismatched++;
        $display("[TB] FAIL fill_cycle%0d: got valid=%b data=%h want valid=%b data=%h",
                 i, data_out_valid, data_out, expValid, expData);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 8'h00, 1'b1);
    compared++;
    if (data_out_valid !== 1'b0 || overflow !== 1'b0 || data_out !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL midreset_state: got valid=%b ovf=%b data=%h want valid=0 ovf=0 data=00",
               data_out_valid, overflow, data_out);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'h00, 1'b0);
      compared++;
      if (data_out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midreset_stale%0d: got valid=%b data=%h want valid=0", i, data_out_valid, data_out);
      end
    end
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    compared++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h5A) begin
      mismatched++;
      $display("[TB] FAIL midreset_fresh: got valid=%b data=%h want valid=1 data=5a", data_out_valid, data_out);
    end
    step(1'b0, 8'h00, 1'b0);
    compared++;
    if (data_out_valid !== 1'b0 || overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_tail: got valid=%b ovf=%b want valid=0 ovf=0", data_out_valid, overflow);
    end
  endtask

  initial begin
    #1;
    $display("[TB] byte_stuffer bench start");
    test_reset();
    test_single_byte();
    test_single_ff();
    test_random_stream();
    test_back_to_back();
    test_fill_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
